// File: rtl/lcd_pkg.sv
// Shared encodings for the LCD window controller: command codes, FSM states
// and display modes, plus the zoom-centre helper used for reset and zoom-in.
package lcd_pkg;

    typedef enum logic [2:0] {
        CMD_LOAD      = 3'd0,
        CMD_ZOOM_IN   = 3'd1,
        CMD_ZOOM_FIT  = 3'd2,
        CMD_RIGHT     = 3'd3,
        CMD_LEFT      = 3'd4,
        CMD_UP        = 3'd5,
        CMD_DOWN      = 3'd6,
        CMD_REDISPLAY = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_UPDATE = 2'd2,
        S_OUT    = 2'd3
    } state_e;

    typedef enum logic {
        MODE_FIT  = 1'b0,
        MODE_ZOOM = 1'b1
    } mode_e;

    // Origin that centres a WIN-wide window on an image dimension.
    function automatic int win_centre(input int img, input int win);
        return (img + 1) / 2 - win / 2;
    endfunction

endpackage

// File: rtl/lcd_frame_ram.sv
// Single-write, single-read frame store with a registered read port.
// Only the read register is reset; the pixel array keeps its contents.
module lcd_frame_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 108,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // rdata only moves on a read, so it naturally holds between windows.
    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/lcd_win_ctrl.sv
// LCD window controller: loads a frame, then streams a WIN x WIN window of it,
// either decimated over the whole image (FIT) or a 1:1 crop at an origin (ZOOM).
module lcd_win_ctrl
    import lcd_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 12,
    parameter int IMG_H = 9,
    parameter int WIN   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int NOUT = WIN * WIN;
    localparam int AW   = $clog2(NPIX);
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int OW   = $clog2(NOUT);
    localparam int WW   = $clog2(WIN);
    localparam int SX   = IMG_W / WIN;
    localparam int SY   = IMG_H / WIN;
    localparam int CX   = win_centre(IMG_W, WIN);
    localparam int CY   = win_centre(IMG_H, WIN);

    state_e        state;
    mode_e         mode;
    logic [XW-1:0] org_x;
    logic [YW-1:0] org_y;
    logic [AW-1:0] load_addr;
    logic [OW-1:0] out_cnt;

    // Read cursor: window index (rd_i, rd_j) and the image pixel it maps to.
    logic [WW-1:0] rd_i, rd_j;
    logic [XW-1:0] rd_col;
    logic [YW-1:0] rd_row;

    cmd_e          cmd_d;
    mode_e         nxt_mode;
    logic [XW-1:0] nxt_x;
    logic [YW-1:0] nxt_y;

    logic [WW-1:0] nx_i, nx_j;
    logic [XW-1:0] nx_col;
    logic [YW-1:0] nx_row;
    logic          cur_last;

    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] raddr;

    assign cmd_d = cmd_e'(cmd);

    function automatic logic [XW-1:0] col_start(input mode_e m, input logic [XW-1:0] x);
        return (m == MODE_FIT) ? XW'(SX / 2) : x;
    endfunction

    function automatic logic [YW-1:0] row_start(input mode_e m, input logic [YW-1:0] y);
        return (m == MODE_FIT) ? YW'(SY / 2) : y;
    endfunction

    // Mode/origin that a non-load command leaves behind.
    always_comb begin
        nxt_mode = mode;
        nxt_x    = org_x;
        nxt_y    = org_y;
        case (cmd_d)
            CMD_ZOOM_IN: begin
                nxt_mode = MODE_ZOOM;
                nxt_x    = XW'(CX);
                nxt_y    = YW'(CY);
            end
            CMD_ZOOM_FIT: nxt_mode = MODE_FIT;
            CMD_RIGHT:
                if (mode == MODE_ZOOM && int'(org_x) < IMG_W - WIN)
                    nxt_x = org_x + XW'(1);
            CMD_LEFT:
                if (mode == MODE_ZOOM && org_x != '0)
                    nxt_x = org_x - XW'(1);
            CMD_UP:
                if (mode == MODE_ZOOM && org_y != '0)
                    nxt_y = org_y - YW'(1);
            CMD_DOWN:
                if (mode == MODE_ZOOM && int'(org_y) < IMG_H - WIN)
                    nxt_y = org_y + YW'(1);
            default: ;
        endcase
    end

    // Cursor step in raster order; the row restarts from the window's left column.
    always_comb begin
        cur_last = (rd_i == WW'(WIN - 1)) && (rd_j == WW'(WIN - 1));
        nx_i     = rd_i;
        nx_j     = rd_j;
        nx_col   = rd_col;
        nx_row   = rd_row;
        if (rd_j == WW'(WIN - 1)) begin
            nx_j   = '0;
            nx_i   = rd_i + WW'(1);
            nx_col = col_start(mode, org_x);
            nx_row = YW'(int'(rd_row) + ((mode == MODE_FIT) ? SY : 1));
        end else begin
            nx_j   = rd_j + WW'(1);
            nx_col = XW'(int'(rd_col) + ((mode == MODE_FIT) ? SX : 1));
        end
    end

    // UPDATE fetches pixel 0; each OUT cycle fetches the pixel shown next cycle.
    assign ram_re = !reset && ((state == S_UPDATE) ||
                    (state == S_OUT && out_cnt != OW'(NOUT - 1)));
    assign ram_we = !reset && (state == S_LOAD);
    assign raddr  = AW'(int'(rd_row) * IMG_W + int'(rd_col));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            mode         <= MODE_FIT;
            org_x        <= XW'(CX);
            org_y        <= YW'(CY);
            busy         <= 1'b0;
            output_valid <= 1'b0;
            load_addr    <= '0;
            out_cnt      <= '0;
            rd_i         <= '0;
            rd_j         <= '0;
            rd_col       <= '0;
            rd_row       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        busy <= 1'b1;
                        rd_i <= '0;
                        rd_j <= '0;
                        if (cmd_d == CMD_LOAD) begin
                            state     <= S_LOAD;
                            load_addr <= '0;
                        end else begin
                            state  <= S_UPDATE;
                            mode   <= nxt_mode;
                            org_x  <= nxt_x;
                            org_y  <= nxt_y;
                            rd_col <= col_start(nxt_mode, nxt_x);
                            rd_row <= row_start(nxt_mode, nxt_y);
                        end
                    end
                end
                S_LOAD: begin
                    load_addr <= load_addr + AW'(1);
                    if (load_addr == AW'(NPIX - 1)) begin
                        state  <= S_UPDATE;
                        mode   <= MODE_FIT;
                        rd_col <= XW'(SX / 2);
                        rd_row <= YW'(SY / 2);
                    end
                end
                S_UPDATE: begin
                    state        <= S_OUT;
                    output_valid <= 1'b1;
                    out_cnt      <= '0;
                    rd_i         <= nx_i;
                    rd_j         <= nx_j;
                    rd_col       <= nx_col;
                    rd_row       <= nx_row;
                end
                S_OUT: begin
                    if (out_cnt == OW'(NOUT - 1)) begin
                        state        <= S_IDLE;
                        output_valid <= 1'b0;
                        busy         <= 1'b0;
                    end else begin
                        out_cnt <= out_cnt + OW'(1);
                        // Hold on the final pixel so the cursor never steps past the window.
                        if (!cur_last) begin
                            rd_i   <= nx_i;
                            rd_j   <= nx_j;
                            rd_col <= nx_col;
                            rd_row <= nx_row;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    lcd_frame_ram #(
        .DW    (DW),
        .DEPTH (NPIX),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (load_addr),
        .wdata (datain),
        .re    (ram_re),
        .raddr (raddr),
        .rdata (dataout)
    );

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Scoreboard bench for lcd_win_ctrl at default parameters, frame pixel k = k.
// Stimulus queues expected window pixels; a negedge monitor pops and compares.
module tb_lcd_win_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] datain = '0;
    logic [2:0] cmd = '0;
    logic       cmd_valid = 1'b0;
    logic [7:0] dataout;
    logic       output_valid;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int exp_last = 0;

    localparam int FIT_EXP [16] = '{13, 16, 19, 22, 37, 40, 43, 46,
                                    61, 64, 67, 70, 85, 88, 91, 94};
    localparam int ZC_EXP  [16] = '{40, 41, 42, 43, 52, 53, 54, 55,
                                    64, 65, 66, 67, 76, 77, 78, 79};

    lcd_win_ctrl #(.DW(8), .IMG_W(12), .IMG_H(9), .WIN(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .datain       (datain),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .dataout      (dataout),
        .output_valid (output_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_fit();
        for (int k = 0; k < 16; k++) exp_q.push_back(FIT_EXP[k]);
    endtask

    task automatic push_zc();
        for (int k = 0; k < 16; k++) exp_q.push_back(ZC_EXP[k]);
    endtask

    // Crop window at origin (x,y): pixel (i,j) = (y+i)*12 + x + j.
    task automatic push_zoom(input int x, input int y);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                exp_q.push_back((y + i) * 12 + x + j);
    endtask

    // Monitor: compare every shown pixel, and check dataout holds otherwise.
    initial begin
        forever begin
            @(negedge clk);
            if (output_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", int'(dataout), -1);
                end else begin
                    exp_last = exp_q.pop_front();
                    chk("pixel", int'(dataout), exp_last);
                end
            end
            if (reset) begin
                exp_q.delete();
                exp_last = 0;
            end else if (!output_valid) begin
                chk("dataout_hold", int'(dataout), exp_last);
            end
        end
    end

    // Issue one command and count busy cycles; optional mid-OUT cmd pulse and reset.
    task automatic issue(input logic [2:0] c, input int exp_busy, input int inject,
                         input int rst_at, input string name);
        int n;
        @(negedge clk);
        cmd       = c;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            datain = 8'(n);
            if (n == inject) begin
                cmd_valid = 1'b1;
                cmd       = 3'd3;
            end else begin
                cmd_valid = 1'b0;
            end
            if (n == rst_at) reset = 1'b1;
            n++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk({name, "_busy_cycles"}, n, exp_busy);
        if (rst_at < 0) begin
            chk({name, "_all_pixels_seen"}, exp_q.size(), 0);
        end else begin
            chk({name, "_valid_after_reset"}, int'(output_valid), 0);
            @(posedge clk); #1;
            reset = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(output_valid), 0);
        chk("reset_dataout", int'(dataout), 0);
        reset = 1'b0;

        // 108 load + 1 update + 16 output cycles
        push_fit();
        issue(3'd0, 125, -1, -1, "load");

        push_zc();
        issue(3'd1, 17, -1, -1, "zoom_in");

        push_zoom(5, 3); issue(3'd3, 17, -1, -1, "right1");
        push_zoom(6, 3); issue(3'd3, 17, -1, -1, "right2");
        push_zoom(7, 3); issue(3'd3, 17, -1, -1, "right3");
        push_zoom(8, 3); issue(3'd3, 17, -1, -1, "right4");
        push_zoom(8, 3); issue(3'd3, 17, -1, -1, "right5_clamp");
        push_zoom(7, 3); issue(3'd4, 17, -1, -1, "left1");

        push_zc();       issue(3'd1, 17, -1, -1, "rezoom");
        push_zoom(4, 2); issue(3'd5, 17, -1, -1, "up1");
        push_zoom(4, 1); issue(3'd5, 17, -1, -1, "up2");
        push_zoom(4, 0); issue(3'd5, 17, -1, -1, "up3");
        push_zoom(4, 0); issue(3'd5, 17, -1, -1, "up4_clamp");
        push_zoom(4, 1); issue(3'd6, 17, -1, -1, "down1");

        push_fit(); issue(3'd2, 17, -1, -1, "zoom_fit");
        push_fit(); issue(3'd6, 17, -1, -1, "fit_down");
        push_fit(); issue(3'd3, 17, -1, -1, "fit_right");

        // right pulse while outputting must not move the origin
        push_zc(); issue(3'd1, 17, 3, -1, "zoom_busy_pulse");
        push_zc(); issue(3'd7, 17, -1, -1, "redisplay_zoom");

        push_zoom(4, 4); issue(3'd6, 17, -1, -1, "down2");
        push_zoom(4, 5); issue(3'd6, 17, -1, -1, "down3");
        push_zoom(4, 5); issue(3'd6, 17, -1, -1, "down4_clamp");
        push_zoom(3, 5); issue(3'd4, 17, -1, -1, "left2");
        push_zoom(2, 5); issue(3'd4, 17, -1, -1, "left3");
        push_zoom(1, 5); issue(3'd4, 17, -1, -1, "left4");
        push_zoom(0, 5); issue(3'd4, 17, -1, -1, "left5");
        push_zoom(0, 5); issue(3'd4, 17, -1, -1, "left6_clamp");

        // reset during the 5th output: busy counted through UPDATE + 5 outputs
        push_zoom(0, 5); issue(3'd7, 6, -1, 5, "reset_mid_out");
        @(posedge clk); #1;
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_dataout", int'(dataout), 0);

        // reset restored FIT mode; memory contents survive
        push_fit(); issue(3'd7, 17, -1, -1, "redisplay_after_reset");
        push_zc();  issue(3'd1, 17, -1, -1, "zoom_after_reset");

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
